// File: rtl/inst_mem_loader.sv
// Instruction memory loader: streams a program in over a ready/valid port until TERM or full, then serves fetches.
// Optional INST_MEM_LOADER_BOUNDS_EN: fetches at or beyond prog_len return TERM and pulse fetch_err.
module inst_mem_loader #(
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 64,
    parameter logic [DATA_W-1:0] TERM   = {DATA_W{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       ld_start,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [$clog2(DEPTH)-1:0]   fetch_addr,
    output logic                       inst_valid,
    output logic [DATA_W-1:0]          inst_data,
    output logic                       loaded,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     prog_len,
    output logic                       fetch_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [LW-1:0]       prog_len_q, prog_len_d;
    logic                loaded_q, loaded_d;
    logic                overflow_q, overflow_d;
    logic                inst_valid_q, inst_valid_d;
    logic [DATA_W-1:0]   inst_data_q, inst_data_d;
    logic                xfer;
    logic                fetch_acc;

    logic [DATA_W-1:0]   mem [DEPTH];

    // ld_start has priority over both a load transfer and a fetch issued in the same cycle.
    assign xfer      = ld_valid && (state_q == LOAD) && !ld_start;
    assign fetch_acc = fetch_valid && (state_q == RUN) && !ld_start;

`ifdef INST_MEM_LOADER_BOUNDS_EN
    logic fetch_err_q, fetch_err_d;
    logic out_of_prog;
    assign out_of_prog = ({1'b0, fetch_addr} >= prog_len_q);
`endif

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        prog_len_d   = prog_len_q;
        loaded_d     = loaded_q;
        overflow_d   = overflow_q;
        inst_valid_d = 1'b0;
        inst_data_d  = inst_data_q;
`ifdef INST_MEM_LOADER_BOUNDS_EN
        fetch_err_d  = 1'b0;
`endif

        if (ld_start) begin
            state_d    = LOAD;
            wptr_d     = '0;
            prog_len_d = '0;
            loaded_d   = 1'b0;
            overflow_d = 1'b0;
        end else if (xfer) begin
            wptr_d     = wptr_q + AW'(1);
            prog_len_d = prog_len_q + LW'(1);
            if (ld_data == TERM) begin
                loaded_d = 1'b1;
                state_d  = RUN;
            end else if (wptr_q == AW'(DEPTH - 1)) begin
                // Memory full without a terminator: keep what we have and run it anyway.
                overflow_d = 1'b1;
                loaded_d   = 1'b1;
                state_d    = RUN;
            end
        end

        if (fetch_acc) begin
            inst_valid_d = 1'b1;
            inst_data_d  = mem[fetch_addr];
`ifdef INST_MEM_LOADER_BOUNDS_EN
            if (out_of_prog) begin
                inst_data_d = TERM;
                fetch_err_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            prog_len_q   <= '0;
            loaded_q     <= 1'b0;
            overflow_q   <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            prog_len_q   <= prog_len_d;
            loaded_q     <= loaded_d;
            overflow_q   <= overflow_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
        end
    end

`ifdef INST_MEM_LOADER_BOUNDS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= fetch_err_d;
        end
    end
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // Storage has no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wptr_q] <= ld_data;
        end
    end

    assign ld_ready    = (state_q == LOAD);
    assign fetch_ready = (state_q == RUN);
    assign inst_valid  = inst_valid_q;
    assign inst_data   = inst_data_q;
    assign loaded      = loaded_q;
    assign overflow    = overflow_q;
    assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: scoreboard of expected fetch responses plus direct status checks.
module tb_inst_mem_loader;

    logic        clk;
    logic        rstn;
    logic        ld_start, ld_valid, ld_ready;
    logic [31:0] ld_data;
    logic        fetch_valid, fetch_ready;
    logic [5:0]  fetch_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        loaded, overflow;
    logic [6:0]  prog_len;
    logic        fetch_err;

    logic        start4, valid4, ready4, fvalid4, fready4, ivalid4, loaded4, ovf4, ferr4;
    logic [31:0] data4, idata4;
    logic [1:0]  faddr4;
    logic [2:0]  plen4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
        bit          chk;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_mem [64];
    bit          m_written [64];
    int          m_state = 0;
    int          m_wptr = 0;
    int          m_len = 0;

    inst_mem_loader u_dut (
        .clk(clk), .rstn(rstn), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
        .inst_valid(inst_valid), .inst_data(inst_data), .loaded(loaded), .overflow(overflow),
        .prog_len(prog_len), .fetch_err(fetch_err)
    );

    inst_mem_loader #(.DEPTH(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .ld_start(start4), .ld_valid(valid4), .ld_ready(ready4),
        .ld_data(data4), .fetch_valid(fvalid4), .fetch_ready(fready4), .fetch_addr(faddr4),
        .inst_valid(ivalid4), .inst_data(idata4), .loaded(loaded4), .overflow(ovf4),
        .prog_len(plen4), .fetch_err(ferr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs and advances the bench's own model of what the next edge should do.
    task automatic applyStimulus(input logic s, input logic v, input logic [31:0] d,
                                 input logic fv, input logic [5:0] fa);
        exp_t e;
        @(posedge clk);
        #1;
        ld_start = s; ld_valid = v; ld_data = d; fetch_valid = fv; fetch_addr = fa;
        if (s) begin
            m_state = 1; m_wptr = 0; m_len = 0;
        end else begin
            if (fv && m_state == 2) begin
                e.due  = cyc + 1;
                e.err  = 1'b0;
                e.chk  = m_written[fa];
                e.data = m_mem[fa];
`ifdef INST_MEM_LOADER_BOUNDS_EN
                if (int'(fa) >= m_len) begin
                    e.err = 1'b1; e.data = 32'hffffffff; e.chk = 1'b1;
                end
`endif
                sbq.push_back(e);
            end
            if (v && m_state == 1) begin
                m_mem[m_wptr] = d;
                m_written[m_wptr] = 1'b1;
                m_len++;
                if (d == 32'hffffffff || m_wptr == 63) m_state = 2;
                m_wptr++;
            end
        end
    endtask

    // Every cycle out of reset: either a scheduled response is due, or inst_valid must be low.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstn) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                checkOutput("inst_valid", inst_valid, 1);
                if (e.chk) checkOutput("inst_data", inst_data, e.data);
                checkOutput("fetch_err", fetch_err, e.err);
            end else begin
                checkOutput("idle_inst_valid", inst_valid, 0);
            end
        end
    end

    initial begin
        rstn = 1'b0;
        ld_start = 0; ld_valid = 0; ld_data = 0; fetch_valid = 0; fetch_addr = 0;
        start4 = 0; valid4 = 0; data4 = 0; fvalid4 = 0; faddr4 = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ld_ready", ld_ready, 0);
        checkOutput("rst_fetch_ready", fetch_ready, 0);
        checkOutput("rst_inst_valid", inst_valid, 0);
        checkOutput("rst_loaded", loaded, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_prog_len", prog_len, 0);
        checkOutput("rst_inst_data", inst_data, 0);
        checkOutput("rst_fetch_err", fetch_err, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Three-word program ending in TERM.
        applyStimulus(1, 0, 32'h0, 0, 0);
        applyStimulus(0, 1, 32'h20010014, 0, 0);
        applyStimulus(0, 1, 32'hafdf0001, 0, 0);
        applyStimulus(0, 1, 32'hffffffff, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("load3_loaded", loaded, 1);
        checkOutput("load3_prog_len", prog_len, 3);
        checkOutput("load3_overflow", overflow, 0);
        checkOutput("load3_fetch_ready", fetch_ready, 1);
        checkOutput("load3_ld_ready", ld_ready, 0);

        applyStimulus(0, 0, 32'h0, 1, 0);
        applyStimulus(0, 0, 32'h0, 1, 1);
        applyStimulus(0, 0, 32'h0, 1, 2);
        applyStimulus(0, 0, 32'h0, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("hold_inst_data", inst_data, 32'hffffffff);

        applyStimulus(0, 0, 32'h0, 1, 6'd5);
        applyStimulus(0, 0, 32'h0, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0);

        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 32'h0, 1, 6'($urandom_range(0, 2)));
        applyStimulus(0, 0, 32'h0, 0, 0);

        // ld_start collides with a fetch and a load word.
        applyStimulus(1, 1, 32'h12345678, 1, 0);
        applyStimulus(0, 0, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("start_prog_len", prog_len, 0);
        checkOutput("start_loaded", loaded, 0);
        checkOutput("start_ld_ready", ld_ready, 1);
        applyStimulus(0, 1, 32'haaaa0001, 0, 0);
        applyStimulus(0, 1, 32'hffffffff, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("reload_prog_len", prog_len, 2);
        checkOutput("reload_loaded", loaded, 1);
        applyStimulus(0, 0, 32'h0, 1, 0);
        applyStimulus(0, 0, 32'h0, 1, 1);
        applyStimulus(0, 0, 32'h0, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0);

        // Asynchronous reset in the middle of a load.
        applyStimulus(1, 0, 32'h0, 0, 0);
        applyStimulus(0, 1, 32'h11110001, 0, 0);
        applyStimulus(0, 1, 32'h22220002, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        checkOutput("arst_ld_ready", ld_ready, 0);
        checkOutput("arst_fetch_ready", fetch_ready, 0);
        checkOutput("arst_inst_valid", inst_valid, 0);
        checkOutput("arst_loaded", loaded, 0);
        checkOutput("arst_overflow", overflow, 0);
        checkOutput("arst_fetch_err", fetch_err, 0);
        checkOutput("arst_prog_len", prog_len, 0);
        checkOutput("arst_inst_data", inst_data, 0);
        m_state = 0; m_wptr = 0; m_len = 0;
        sbq.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 32'h33330003, 0, 0);
            @(negedge clk);
            checkOutput("post_rst_ld_ready", ld_ready, 0);
            checkOutput("post_rst_prog_len", prog_len, 0);
        end
        applyStimulus(1, 0, 32'h0, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("restart_ld_ready", ld_ready, 1);

        // Overflow on the four-entry instance.
        @(posedge clk);
        #1 start4 = 1;
        @(posedge clk);
        #1 start4 = 0;
        valid4 = 1;
        for (int i = 0; i < 4; i++) begin
            data4 = 32'(i + 1);
            @(negedge clk);
            checkOutput("d4_ld_ready", ready4, 1);
            @(posedge clk);
            #1;
        end
        data4 = 32'h5;
        @(negedge clk);
        checkOutput("d4_overflow", ovf4, 1);
        checkOutput("d4_prog_len", plen4, 4);
        checkOutput("d4_loaded", loaded4, 1);
        checkOutput("d4_fetch_ready", fready4, 1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("d4_no_fifth_ready", ready4, 0);
            @(negedge clk);
        end
        checkOutput("d4_prog_len_hold", plen4, 4);
        @(posedge clk);
        #1 valid4 = 0;
        fvalid4 = 1;
        faddr4 = 2'd3;
        @(posedge clk);
        #1 fvalid4 = 0;
        @(negedge clk);
        checkOutput("d4_inst_valid", ivalid4, 1);
        checkOutput("d4_inst_data", idata4, 32'h4);
        checkOutput("d4_fetch_err", ferr4, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of instruction words (>=2).
REQ-003 SHALL have parameter TERM, default all-ones of DATA_W, the end-of-program sentinel word.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1, reset: asynchronous and active-low.
REQ-006 SHALL have port ld_start, input, 1, a pulse that begins a new program load.
REQ-007 SHALL have ports ld_valid (input, 1), ld_ready (output, 1) and ld_data (input, DATA_W), a load word handshake.
REQ-008 SHALL have ports fetch_valid (input, 1), fetch_ready (output, 1) and fetch_addr (input, clog2(DEPTH)), a fetch request.
REQ-009 SHALL have ports inst_valid (output, 1) and inst_data (output, DATA_W), the fetch response.
REQ-010 SHALL have ports loaded (output, 1), overflow (output, 1) and prog_len (output, clog2(DEPTH)+1), the load status.
REQ-011 SHALL have port fetch_err (output, 1), an out-of-program fetch pulse.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD and RUN.
REQ-013 SHALL transition from any state to LOAD on ld_start, clearing the write pointer, prog_len, loaded and overflow the same cycle.
REQ-014 SHALL drive ld_ready=1 only in LOAD; a word transfers when ld_valid&&ld_ready.
REQ-015 SHALL, on each transfer, write mem[wptr]=ld_data and increment wptr and prog_len by 1.
REQ-016 SHALL, on a transfer whose ld_data==TERM, store that word, count it in prog_len, set loaded=1 and enter RUN on the next cycle.
REQ-017 SHALL, when the transfer at wptr==DEPTH-1 is not TERM, set overflow=1 and loaded=1 with prog_len=DEPTH, and enter RUN.
REQ-018 SHALL let ld_start win over a simultaneous ld_valid transfer; that word is discarded.
REQ-019 SHALL drive fetch_ready=1 only in RUN; a fetch is accepted when fetch_valid&&fetch_ready.
REQ-020 SHALL respond to an accepted fetch in the next cycle with inst_valid=1 for exactly one cycle and inst_data=mem[fetch_addr].
REQ-021 SHALL support back-to-back fetches at one per cycle with no bubbles.
REQ-022 SHALL hold inst_data at its last value when inst_valid=0.
REQ-023 SHALL cancel a fetch accepted in the same cycle as ld_start: inst_valid=0 in the next cycle.
REQ-024 SHALL leave memory contents unaffected by fetches and by ld_start.

Reset
REQ-025 SHALL, while rstn=0, force state IDLE and wptr=0.
REQ-026 SHALL, while rstn=0, force ld_ready, fetch_ready, inst_valid, loaded, overflow and fetch_err to 0.
REQ-027 SHALL, while rstn=0, force prog_len and inst_data to 0.
REQ-028 SHALL not reset memory array contents.
REQ-029 SHALL abandon an in-progress load on reset, so that a new ld_start is required.

Configuration
REQ-030 SHALL, when macro INST_MEM_LOADER_BOUNDS_EN is defined, return inst_data=TERM and pulse fetch_err=1 alongside inst_valid for an accepted fetch with fetch_addr>=prog_len.
REQ-031 SHALL, when INST_MEM_LOADER_BOUNDS_EN is undefined, return raw mem[fetch_addr] for any address and tie fetch_err to 0.

Verification
REQ-032 SHALL cover: reset, ld_start, then load 0x20010014, 0xafdf0001, 0xffffffff -> loaded=1, prog_len=3, overflow=0, fetch_ready=1 one cycle after the third word.
REQ-033 SHALL cover: after REQ-032, fetch addresses 0, 1, 2 in consecutive cycles -> inst_data 0x20010014, 0xafdf0001, 0xffffffff in the 3 following cycles, each with inst_valid=1.
REQ-034 SHALL cover: DEPTH=4, load 4 non-TERM words -> overflow=1, prog_len=4, RUN entered, and no fifth ld_ready.
REQ-035 SHALL cover: with BOUNDS_EN and prog_len=3, fetch address 5 -> inst_data=0xffffffff and fetch_err=1 for one cycle; without BOUNDS_EN, fetch_err=0.
REQ-036 SHALL cover: ld_start asserted in the same cycle as an accepted fetch and an ld_valid word -> inst_valid=0, prog_len=0 and the word is not stored.
REQ-037 SHALL cover: rstn driven low mid-load after 2 words -> all outputs 0 immediately (asynchronous), and ld_ready stays 0 until ld_start.
